// File: rtl/seg_mux_capture_pkg.sv
// Shared definitions for the multiplexed 7-segment display capture block:
// segment bit positions, the hex glyph table and the capture FSM states.
package seg_mux_capture_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam int NUM_DIGITS = 4;

    // Entry k is the a..g pattern that displays hex digit k.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        ST_SYNC    = 1'b0,
        ST_COLLECT = 1'b1
    } cap_state_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seg_mux_capture_if.sv
// Display-side inputs and frame-side handshake of the capture block.
// The master modport is the capture block itself; slave is its environment.
interface seg_mux_capture_if;
    logic [7:0]  segmentos;
    logic [3:0]  sel_seg;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        bad_glyph;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        sync_err;

    modport master (
        input  segmentos, sel_seg, out_ready,
        output value, dp, bad_glyph, out_valid, overrun, sync_err
    );

    modport slave (
        output segmentos, sel_seg, out_ready,
        input  value, dp, bad_glyph, out_valid, overrun, sync_err
    );
endinterface

// File: rtl/seg_mux_capture_seg7_to_hex.sv
// Combinational 7-segment (a..g) to hex nibble decoder; unknown patterns
// decode to 0 with the invalid flag raised.
module seg7_to_hex
    import seg_mux_capture_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       invalid_o
);
    logic [15:0] hit;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_match
            assign hit[gi] = (pattern_i == GLYPH_TABLE[gi]);
        end
    endgenerate

    always_comb begin
        nibble_o = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (hit[k]) nibble_o = 4'(k);
        end
    end

    assign invalid_o = ~|hit;
endmodule

// File: rtl/seg_mux_capture.sv
// Captures four multiplexed 7-segment digits into a hex frame and presents
// it through a valid/ready register with overrun and sync-error reporting.
module seg_mux_capture
    import seg_mux_capture_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    seg_mux_capture_if.master bus
);
    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]  CAPTURE_AT = 8'(STABLE_CYCLES - 1);
    localparam logic [15:0] TMO_MAX    = 16'(TIMEOUT_CYCLES);

    logic [11:0] sync1_q, sync2_q, prev_q;
    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic [15:0] tmo_q, tmo_d;
    cap_state_e  state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dps_q, dps_d;
    logic [3:0]  bads_q, bads_d;
    logic        frame_done;
    logic        sync_err_d;

    logic [15:0] value_q, value_d;
    logic [3:0]  dp_q, dp_d;
    logic        bad_q, bad_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        sync_err_q;

    logic [3:0]  cap_sel;
    logic [7:0]  cap_seg;
    logic [3:0]  cap_nib;
    logic        cap_bad;
    logic        capture, cap_digit, cap_multi;

    // prev_q holds the sample the stability count refers to, so capture
    // data is taken from it rather than from a possibly just-changed sync2_q.
    assign capture   = (stab_cnt_q == CAPTURE_AT);
    assign cap_sel   = prev_q[11:8];
    assign cap_seg   = prev_q[7:0] ^ {8{SEG_ACTIVE_LOW}};
    assign cap_digit = capture && is_onehot4(cap_sel);
    assign cap_multi = capture && (cap_sel != 4'd0) && !is_onehot4(cap_sel);

    seg7_to_hex u_dec (
        .pattern_i (cap_seg[SEG_G:SEG_A]),
        .nibble_o  (cap_nib),
        .invalid_o (cap_bad)
    );

    always_comb begin
        stab_cnt_d = 8'd0;
        if (sync2_q == prev_q) begin
            stab_cnt_d = (stab_cnt_q == STABLE_MAX) ? stab_cnt_q : stab_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        digits_d   = digits_q;
        dps_d      = dps_q;
        bads_d     = bads_q;
        frame_done = 1'b0;
        sync_err_d = 1'b0;
        tmo_d      = (state_q == ST_COLLECT && !cap_digit) ? tmo_q + 16'd1 : 16'd0;

        if (cap_digit && (state_q == ST_COLLECT || cap_sel == 4'b0001)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_sel[i]) begin
                    digits_d[i*4 +: 4] = cap_nib;
                    dps_d[i]           = cap_seg[SEG_DP];
                    bads_d[i]          = cap_bad;
                end
            end
        end

        if (cap_multi) begin
            sync_err_d = 1'b1;
            mask_d     = 4'd0;
            state_d    = ST_SYNC;
            tmo_d      = 16'd0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (cap_digit && cap_sel == 4'b0001) begin
                        mask_d  = 4'b0001;
                        state_d = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (tmo_q == TMO_MAX) begin
                        sync_err_d = 1'b1;
                        mask_d     = 4'd0;
                        state_d    = ST_SYNC;
                        tmo_d      = 16'd0;
                    end else if (cap_digit) begin
                        mask_d = mask_q | cap_sel;
                        if (mask_d == 4'b1111) begin
                            frame_done = 1'b1;
                            mask_d     = 4'd0;
                            state_d    = ST_SYNC;
                        end
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    always_comb begin
        value_d   = value_q;
        dp_d      = dp_q;
        bad_d     = bad_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (frame_done && (!valid_q || bus.out_ready)) begin
            value_d = digits_d;
            dp_d    = dps_d;
            bad_d   = |bads_d;
            valid_d = 1'b1;
        end else begin
            if (valid_q && bus.out_ready) valid_d = 1'b0;
            if (frame_done) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            stab_cnt_q <= '0;
            tmo_q      <= '0;
            state_q    <= ST_SYNC;
            mask_q     <= '0;
            digits_q   <= '0;
            dps_q      <= '0;
            bads_q     <= '0;
            value_q    <= '0;
            dp_q       <= '0;
            bad_q      <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            sync1_q    <= {bus.sel_seg, bus.segmentos};
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            stab_cnt_q <= stab_cnt_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            mask_q     <= mask_d;
            digits_q   <= digits_d;
            dps_q      <= dps_d;
            bads_q     <= bads_d;
            value_q    <= value_d;
            dp_q       <= dp_d;
            bad_q      <= bad_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign bus.value     = value_q;
    assign bus.dp        = dp_q;
    assign bus.bad_glyph = bad_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.sync_err  = sync_err_q;
endmodule

// File: doc/seg_mux_capture.md
SEG_MUX_CAPTURE -- requirements
Module: seg_mux_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples required before a digit is captured (legal range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: cycles allowed between captures inside a frame (legal range 16..65535).
REQ-003 Parameter SEG_ACTIVE_LOW, default 0: 1 means segment inputs are inverted before decoding.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 segmentos  input  8  display segment bus; bit0..6 = a..g, bit7 = dp; asynchronous to clk.
REQ-007 sel_seg  input  4  digit select, one-hot active-high, bit0 = least-significant digit; asynchronous to clk.
REQ-008 value  output  16  captured hex digits, nibble i = digit i.
REQ-009 dp  output  4  captured decimal points, bit i = digit i.
REQ-010 bad_glyph  output  1  at least one digit in the presented frame had a non-hex pattern.
REQ-011 out_valid  output  1  frame available.
REQ-012 out_ready  input  1  consumer accepts the frame.
REQ-013 overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-014 sync_err  output  1  one-cycle pulse on a multi-hot select or a timeout abort.

Function
REQ-015 Both input buses pass through a 2-flop synchronizer; all logic uses the synchronized copies.
REQ-016 Stability counter: increments while synchronized {sel_seg, segmentos} equals the previous sample, clears to 0 on any change, saturates at STABLE_CYCLES.
REQ-017 A capture fires on the cycle the counter reaches STABLE_CYCLES-1, at most once per dwell; the next capture requires a sample change first.
REQ-018 sel_seg = 0000 (blanking) never captures and does not affect frame state.
REQ-019 A multi-hot sel_seg that becomes stable pulses sync_err, discards partial data, and sends the FSM to SYNC.
REQ-020 The FSM has two states, SYNC and COLLECT; reset enters SYNC.
REQ-021 In SYNC, a capture with sel_seg = 0001 stores digit 0, sets collect mask to 0001, and moves to COLLECT; other captures are ignored.
REQ-022 In COLLECT, a capture of digit i stores its nibble and dp and sets mask bit i; recapturing an already-set digit overwrites it.
REQ-023 When the mask becomes 1111, the frame is complete and the FSM returns to SYNC on the next cycle.
REQ-024 Decode map (after optional inversion, dp ignored): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
REQ-025 Any other pattern decodes to nibble 0 and sets that frame's bad_glyph.
REQ-026 Timeout counter clears on every capture; reaching TIMEOUT_CYCLES in COLLECT pulses sync_err and returns to SYNC without presenting data.
REQ-027 Output register: when a frame completes and out_valid=0 (or out_valid&&out_ready that cycle), value/dp/bad_glyph load and out_valid=1 on the next cycle.
REQ-028 out_valid and data stay stable until out_valid&&out_ready; out_valid then clears unless a new frame loads in the same cycle.
REQ-029 A frame completing while out_valid=1 and out_ready=0 is dropped, overrun pulses, and the held frame is kept.
REQ-030 Latency: a stable input change leads to capture after 2+STABLE_CYCLES cycles; final capture to out_valid is 1 cycle.

Reset
REQ-031 rst clears the synchronizers, counters, mask, and FSM (to SYNC) immediately, independent of clk.
REQ-032 While rst is high, value=0000, dp=0, bad_glyph=0, out_valid=0, overrun=0, sync_err=0.
REQ-033 Reset asserted mid-frame or mid-handshake discards all partial and held data; no pulse is generated on exit.

Structure
REQ-034 A shared package holds segment bit-position constants, the 16-entry glyph table, and the FSM state typedef.
REQ-035 Decoding is a sub-module seg7_to_hex: pattern in, nibble plus invalid flag out, purely combinational.

Verification
REQ-036 Scan digits 0..3 with patterns 06, 5B, 4F, 66 (no dp), dwell 10 cycles each, out_ready=1 → one out_valid pulse, value=4321, dp=0, bad_glyph=0.
REQ-037 Same scan with out_ready=0 for two full frames → first frame held (value=4321), exactly one overrun pulse at the second frame's completion.
REQ-038 Digit 2 pattern 49 with dp set → value=4021, dp=0100, bad_glyph=1.
REQ-039 sel_seg=0011 held 10 cycles mid-frame → sync_err pulse, no out_valid, next clean scan yields value=4321.
REQ-040 Dwell of STABLE_CYCLES-1 cycles on digit 1, and separately the scan stalled after digit 1 for TIMEOUT_CYCLES → no capture; timeout gives sync_err, no out_valid.
REQ-041 rst pulsed asynchronously between clk edges after digit 2 → all outputs 0 immediately; a later full scan presents a correct frame.
